// File: rtl/async_sram_ctrl.sv
// Sequencer driving the gf180mcu async SRAM PHY ctrl_* ports from byte/halfword/word requests.
// Define ASYNC_SRAM_CTRL_WORD_EN to split word requests into two halfword SRAM cycles.
module async_sram_ctrl #(
   parameter int N_SRAM_A   = 18,
   parameter int N_SRAM_DQ  = 16,
   parameter int READ_WAIT  = 1,
   parameter int WRITE_WAIT = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [1:0]           req_size,
   input  logic [N_SRAM_A:0]    req_addr,
   input  logic [31:0]          req_wdata,
   output logic                 resp_valid,
   output logic [31:0]          resp_rdata,
   output logic [N_SRAM_A-1:0]  ctrl_addr,
   output logic [N_SRAM_DQ-1:0] ctrl_dq_out,
   output logic [N_SRAM_DQ-1:0] ctrl_dq_oe,
   input  logic [N_SRAM_DQ-1:0] ctrl_dq_in,
   output logic                 ctrl_ce_n,
   output logic                 ctrl_we_n,
   output logic                 ctrl_oe_n,
   output logic [1:0]           ctrl_byte_n
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_DRIVE = 3'd1,
      RD_CAPT  = 3'd2,
      TURN     = 3'd3,
      WR_DRIVE = 3'd4,
      WR_HOLD  = 3'd5
   } state_e;

   localparam logic [2:0] RD_WAIT_C = 3'(READ_WAIT);
   localparam logic [2:0] WR_WAIT_C = 3'(WRITE_WAIT);

   state_e               state_q, state_d;
   logic [2:0]           cnt_q, cnt_d;
   logic                 last_rd_q, last_rd_d;
   logic                 resp_valid_q, resp_valid_d;
   logic                 resp_rd_q, resp_rd_d;
   logic [N_SRAM_A-1:0]  addr_q, addr_d;
   logic [N_SRAM_DQ-1:0] dq_out_q, dq_out_d;
   logic [N_SRAM_DQ-1:0] dq_oe_q, dq_oe_d;
   logic                 ce_n_q, ce_n_d;
   logic                 we_n_q, we_n_d;
   logic                 oe_n_q, oe_n_d;
   logic [1:0]           byte_n_q, byte_n_d;
`ifdef ASYNC_SRAM_CTRL_WORD_EN
   logic                 word_q, word_d;
   logic                 second_q, second_d;
   logic [15:0]          wdata_hi_q, wdata_hi_d;
   logic [15:0]          lo_q, lo_d;
`endif

   logic                 size_word_s;
   logic [N_SRAM_A-1:0]  req_idx_s;
   logic [1:0]           req_byte_n_s;
   logic [15:0]          req_hw_s;
   logic                 final_hw_s;

   // Request decode: halfword index, byte lanes and the outgoing halfword.
   always_comb begin
      size_word_s = req_size[1];
      req_idx_s   = req_addr[N_SRAM_A:1];
      if (size_word_s) begin
         req_idx_s[0] = 1'b0;
         req_hw_s     = req_wdata[15:0];
      end else begin
         req_hw_s     = req_addr[1] ? req_wdata[31:16] : req_wdata[15:0];
      end
      if (req_size == 2'd0) begin
         req_byte_n_s = req_addr[0] ? 2'b01 : 2'b10;
      end else begin
         req_byte_n_s = 2'b00;
      end
`ifdef ASYNC_SRAM_CTRL_WORD_EN
      final_hw_s = !word_q || second_q;
`else
      final_hw_s = 1'b1;
`endif
   end

   // Next-state and next-output computation for the sequencing FSM.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_rd_d    = last_rd_q;
      resp_valid_d = 1'b0;
      resp_rd_d    = 1'b0;
      addr_d       = addr_q;
      dq_out_d     = dq_out_q;
      dq_oe_d      = dq_oe_q;
      ce_n_d       = ce_n_q;
      we_n_d       = we_n_q;
      oe_n_d       = oe_n_q;
      byte_n_d     = byte_n_q;
`ifdef ASYNC_SRAM_CTRL_WORD_EN
      word_d       = word_q;
      second_d     = second_q;
      wdata_hi_d   = wdata_hi_q;
      lo_d         = lo_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d   = req_idx_s;
               byte_n_d = req_byte_n_s;
               dq_out_d = req_hw_s;
`ifdef ASYNC_SRAM_CTRL_WORD_EN
               word_d     = size_word_s;
               second_d   = 1'b0;
               wdata_hi_d = req_wdata[31:16];
`endif
               if (req_write) begin
                  last_rd_d = 1'b0;
                  if (last_rd_q) begin
                     state_d = TURN;
                  end else begin
                     state_d = WR_DRIVE;
                     ce_n_d  = 1'b0;
                     we_n_d  = 1'b0;
                     dq_oe_d = {N_SRAM_DQ{1'b1}};
                     cnt_d   = WR_WAIT_C;
                  end
               end else begin
                  last_rd_d = 1'b1;
                  state_d   = RD_DRIVE;
                  ce_n_d    = 1'b0;
                  oe_n_d    = 1'b0;
                  cnt_d     = RD_WAIT_C;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD_DRIVE: begin
            if (cnt_q == 3'd0) begin
               state_d      = RD_CAPT;
               ce_n_d       = 1'b1;
               oe_n_d       = 1'b1;
               resp_valid_d = final_hw_s;
               resp_rd_d    = final_hw_s;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RD_CAPT: begin
`ifdef ASYNC_SRAM_CTRL_WORD_EN
            if (!final_hw_s) begin
               lo_d     = ctrl_dq_in;
               second_d = 1'b1;
               addr_d   = {addr_q[N_SRAM_A-1:1], 1'b1};
               state_d  = RD_DRIVE;
               ce_n_d   = 1'b0;
               oe_n_d   = 1'b0;
               cnt_d    = RD_WAIT_C;
            end else begin
               state_d  = IDLE;
               byte_n_d = 2'b11;
            end
`else
            state_d  = IDLE;
            byte_n_d = 2'b11;
`endif
         end
         TURN: begin
            state_d = WR_DRIVE;
            ce_n_d  = 1'b0;
            we_n_d  = 1'b0;
            dq_oe_d = {N_SRAM_DQ{1'b1}};
            cnt_d   = WR_WAIT_C;
         end
         WR_DRIVE: begin
            if (cnt_q == 3'd0) begin
               state_d      = WR_HOLD;
               we_n_d       = 1'b1;
               resp_valid_d = final_hw_s;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         WR_HOLD: begin
`ifdef ASYNC_SRAM_CTRL_WORD_EN
            if (!final_hw_s) begin
               second_d = 1'b1;
               addr_d   = {addr_q[N_SRAM_A-1:1], 1'b1};
               dq_out_d = wdata_hi_q;
               we_n_d   = 1'b0;
               cnt_d    = WR_WAIT_C;
               state_d  = WR_DRIVE;
            end else begin
               state_d  = IDLE;
               ce_n_d   = 1'b1;
               dq_oe_d  = {N_SRAM_DQ{1'b0}};
               byte_n_d = 2'b11;
            end
`else
            state_d  = IDLE;
            ce_n_d   = 1'b1;
            dq_oe_d  = {N_SRAM_DQ{1'b0}};
            byte_n_d = 2'b11;
`endif
         end
         default: begin
            state_d  = IDLE;
            ce_n_d   = 1'b1;
            we_n_d   = 1'b1;
            oe_n_d   = 1'b1;
            dq_oe_d  = {N_SRAM_DQ{1'b0}};
            byte_n_d = 2'b11;
         end
      endcase
   end

   // FSM state and registered PHY/response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         last_rd_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rd_q    <= 1'b0;
         addr_q       <= {N_SRAM_A{1'b0}};
         dq_out_q     <= {N_SRAM_DQ{1'b0}};
         dq_oe_q      <= {N_SRAM_DQ{1'b0}};
         ce_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         byte_n_q     <= 2'b11;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_rd_q    <= last_rd_d;
         resp_valid_q <= resp_valid_d;
         resp_rd_q    <= resp_rd_d;
         addr_q       <= addr_d;
         dq_out_q     <= dq_out_d;
         dq_oe_q      <= dq_oe_d;
         ce_n_q       <= ce_n_d;
         we_n_q       <= we_n_d;
         oe_n_q       <= oe_n_d;
         byte_n_q     <= byte_n_d;
      end
   end

`ifdef ASYNC_SRAM_CTRL_WORD_EN
   // Second-halfword bookkeeping and the held low half of a word read.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q     <= 1'b0;
         second_q   <= 1'b0;
         wdata_hi_q <= 16'h0000;
         lo_q       <= 16'h0000;
      end else begin
         word_q     <= word_d;
         second_q   <= second_d;
         wdata_hi_q <= wdata_hi_d;
         lo_q       <= lo_d;
      end
   end
`endif

   // Read data is assembled from the PHY sample present in the capture cycle.
   always_comb begin
      if (resp_rd_q) begin
`ifdef ASYNC_SRAM_CTRL_WORD_EN
         if (word_q) begin
            resp_rdata = {ctrl_dq_in, lo_q};
         end else begin
            resp_rdata = {ctrl_dq_in, ctrl_dq_in};
         end
`else
         resp_rdata = {ctrl_dq_in, ctrl_dq_in};
`endif
      end else begin
         resp_rdata = 32'h0000_0000;
      end
   end

   assign req_ready   = (state_q == IDLE) && !rst;
   assign resp_valid  = resp_valid_q;
   assign ctrl_addr   = addr_q;
   assign ctrl_dq_out = dq_out_q;
   assign ctrl_dq_oe  = dq_oe_q;
   assign ctrl_ce_n   = ce_n_q;
   assign ctrl_we_n   = we_n_q;
   assign ctrl_oe_n   = oe_n_q;
   assign ctrl_byte_n = byte_n_q;

endmodule

// File: tb/tb_async_sram_ctrl.sv
// Directed scoreboard bench for async_sram_ctrl with a registered-sample SRAM/PHY model.
// Expectations follow ASYNC_SRAM_CTRL_WORD_EN when it is defined for the build.
module tb_async_sram_ctrl;

   localparam int N_A = 18;
   localparam int RW  = 1;
   localparam int WW  = 0;
`ifdef ASYNC_SRAM_CTRL_WORD_EN
   localparam bit WORD_EN = 1'b1;
`else
   localparam bit WORD_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic            req_write = 1'b0;
   logic [1:0]      req_size = 2'd0;
   logic [N_A:0]    req_addr = '0;
   logic [31:0]     req_wdata = 32'h0;
   logic            resp_valid;
   logic [31:0]     resp_rdata;
   logic [N_A-1:0]  ctrl_addr;
   logic [15:0]     ctrl_dq_out;
   logic [15:0]     ctrl_dq_oe;
   logic [15:0]     ctrl_dq_in;
   logic            ctrl_ce_n, ctrl_we_n, ctrl_oe_n;
   logic [1:0]      ctrl_byte_n;

   async_sram_ctrl #(.N_SRAM_A(N_A), .N_SRAM_DQ(16), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .ctrl_addr(ctrl_addr), .ctrl_dq_out(ctrl_dq_out), .ctrl_dq_oe(ctrl_dq_oe),
      .ctrl_dq_in(ctrl_dq_in), .ctrl_ce_n(ctrl_ce_n), .ctrl_we_n(ctrl_we_n),
      .ctrl_oe_n(ctrl_oe_n), .ctrl_byte_n(ctrl_byte_n)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM + PHY model: read data sampled at the edge, so it shows up in the capture cycle.
   logic [15:0] mem [0:255];
   logic [15:0] dq_in_r = 16'h0000;
   assign ctrl_dq_in = dq_in_r;

   function automatic logic [7:0] mem_idx(input logic [N_A-1:0] a);
      return {a[N_A-1], a[6:0]};
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h20] <= 16'h1234;
      mem[8'h21] <= 16'hABCD;
   end

   always @(posedge clk) begin
      if (ctrl_ce_n === 1'b0 && ctrl_oe_n === 1'b0) dq_in_r <= mem[mem_idx(ctrl_addr)];
      if (ctrl_ce_n === 1'b0 && ctrl_we_n === 1'b0) begin
         if (!ctrl_byte_n[0]) mem[mem_idx(ctrl_addr)][7:0]  <= ctrl_dq_out[7:0];
         if (!ctrl_byte_n[1]) mem[mem_idx(ctrl_addr)][15:8] <= ctrl_dq_out[15:8];
      end
   end

   // Turnaround monitor: smallest distance from an oe_n-low cycle to a dq_oe rise.
   int last_oe_cyc = -100;
   int min_gap = 1000;
   int rise_cnt = 0;
   logic [15:0] prev_oe = 16'h0000;
   always @(negedge clk) begin
      if (ctrl_oe_n === 1'b0) last_oe_cyc <= cyc;
      if (ctrl_dq_oe === 16'hFFFF && prev_oe !== 16'hFFFF) begin
         rise_cnt <= rise_cnt + 1;
         if (cyc - last_oe_cyc < min_gap) min_gap <= cyc - last_oe_cyc;
      end
      prev_oe <= ctrl_dq_oe;
   end

   typedef struct {
      logic        is_rd;
      logic [31:0] rdata;
      int          lat;
   } exp_t;
   exp_t sb_q[$];

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_resp(input logic is_rd, input logic [31:0] rdata, input int lat);
      exp_t e;
      e.is_rd = is_rd;
      e.rdata = rdata;
      e.lat   = lat;
      sb_q.push_back(e);
   endtask

   task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                         input logic [N_A:0] a, input logic [31:0] wd, output int t);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_size  = sz;
      req_addr  = a;
      req_wdata = wd;
      t = -1;
      for (int i = 0; i < 20 && t < 0; i++) begin
         if (req_ready === 1'b1) t = cyc;
         else @(negedge clk);
      end
      check({tag, "_accept"}, 32'(t >= 0), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   // Observations gathered while waiting for the response of one request.
   logic          o_ce_first;
   logic [N_A-1:0] o_addr0, o_addr1;
   logic [15:0]   o_dq0, o_dq1;
   logic [1:0]    o_byte;
   int            o_we, o_oe, o_tr;

   task automatic wait_resp(input string tag, input int t);
      exp_t        e;
      logic [31:0] rd;
      bit          seen_ce;
      o_tr = -1; o_we = 0; o_oe = 0; seen_ce = 1'b0; rd = 32'h0;
      o_addr0 = '0; o_addr1 = '0; o_dq0 = 16'h0; o_dq1 = 16'h0; o_byte = 2'b11; o_ce_first = 1'b0;
      for (int i = 0; i < 40 && o_tr < 0; i++) begin
         @(negedge clk);
         if (i == 0) o_ce_first = ctrl_ce_n;
         if (ctrl_ce_n === 1'b0) begin
            if (!seen_ce) begin
               o_addr0 = ctrl_addr;
               o_byte  = ctrl_byte_n;
               seen_ce = 1'b1;
            end
            o_addr1 = ctrl_addr;
         end
         if (ctrl_we_n === 1'b0) begin
            if (o_we == 0) o_dq0 = ctrl_dq_out;
            o_dq1 = ctrl_dq_out;
            o_we++;
         end
         if (ctrl_oe_n === 1'b0) o_oe++;
         if (resp_valid === 1'b1) begin
            o_tr = cyc;
            rd   = resp_rdata;
         end
      end
      e = sb_q.pop_front();
      check({tag, "_resp_seen"}, 32'(o_tr >= 0), 32'd1);
      check({tag, "_latency"}, 32'(o_tr - t), 32'(e.lat));
      if (e.is_rd) check({tag, "_rdata"}, rd, e.rdata);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ce_n"},   32'(ctrl_ce_n),   32'd1);
      check({tag, "_we_n"},   32'(ctrl_we_n),   32'd1);
      check({tag, "_oe_n"},   32'(ctrl_oe_n),   32'd1);
      check({tag, "_byte_n"}, 32'(ctrl_byte_n), 32'd3);
      check({tag, "_dq_oe"},  32'(ctrl_dq_oe),  32'd0);
      check({tag, "_addr"},   32'(ctrl_addr),   32'd0);
      check({tag, "_dq_out"}, 32'(ctrl_dq_out), 32'd0);
      check({tag, "_resp_v"}, 32'(resp_valid),  32'd0);
      check({tag, "_rdata"},  resp_rdata,       32'd0);
      check({tag, "_ready"},  32'(req_ready),   32'd0);
   endtask

   initial begin
      int t, tr_prev, resp_hits;

      // power-on reset
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b0;
      @(negedge clk);
      check("por_ready_after", 32'(req_ready), 32'd1);

      // reset held 3 cycles in the middle of a word write
      do_req("rstw", 1'b1, 2'd2, 19'h00008, 32'hDEADBEEF, t);
      @(negedge clk);
      rst = 1'b1;
      resp_hits = (resp_valid === 1'b1) ? 1 : 0;
      @(negedge clk);
      check_reset_outputs("midrst");
      @(negedge clk);
      resp_hits += (resp_valid === 1'b1) ? 1 : 0;
      @(negedge clk);
      resp_hits += (resp_valid === 1'b1) ? 1 : 0;
      check("midrst_ready_in_rst", 32'(req_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      resp_hits += (resp_valid === 1'b1) ? 1 : 0;
      check("midrst_ready_after", 32'(req_ready), 32'd1);
      check("midrst_no_resp", 32'(resp_hits), 32'd0);

      // halfword write
      expect_resp(1'b0, 32'h0, 2 + WW);
      do_req("hw_wr", 1'b1, 2'd1, 19'h00010, 32'h0000A5C3, t);
      wait_resp("hw_wr", t);
      check("hw_wr_addr", 32'(o_addr0), 32'h8);
      check("hw_wr_dq", 32'(o_dq0), 32'hA5C3);
      check("hw_wr_we_cycles", 32'(o_we), 32'd1);
      check("hw_wr_byte_n", 32'(o_byte), 32'd0);
      tr_prev = o_tr;

      // byte write to the upper lane, issued back-to-back
      expect_resp(1'b0, 32'h0, 2 + WW);
      do_req("b_wr", 1'b1, 2'd0, 19'h00003, 32'h77000000, t);
      check("b2b_accept", 32'(t), 32'(tr_prev + 1));
      wait_resp("b_wr", t);
      check("b_wr_addr", 32'(o_addr0), 32'h1);
      check("b_wr_byte_n", 32'(o_byte), 32'b01);
      check("b_wr_dq", 32'(o_dq0), 32'h7700);

      // word write
      expect_resp(1'b0, 32'h0, WORD_EN ? 2 * (2 + WW) : 2 + WW);
      do_req("w_wr", 1'b1, 2'd2, 19'h00004, 32'h11112222, t);
      wait_resp("w_wr", t);
      check("w_wr_addr0", 32'(o_addr0), 32'h2);
      check("w_wr_addr1", 32'(o_addr1), WORD_EN ? 32'h3 : 32'h2);
      check("w_wr_dq0", 32'(o_dq0), 32'h2222);
      check("w_wr_dq1", 32'(o_dq1), WORD_EN ? 32'h1111 : 32'h2222);
      check("w_wr_we_cycles", 32'(o_we), WORD_EN ? 32'd2 : 32'd1);

      // top word of the SRAM, size 3 treated as word
      expect_resp(1'b0, 32'h0, WORD_EN ? 2 * (2 + WW) : 2 + WW);
      do_req("top_wr", 1'b1, 2'd3, 19'h7FFFC, 32'h5555AAAA, t);
      wait_resp("top_wr", t);
      check("top_wr_addr0", 32'(o_addr0), 32'h3FFFE);
      check("top_wr_addr1", 32'(o_addr1), WORD_EN ? 32'h3FFFF : 32'h3FFFE);

      // word read of preloaded halfwords 0x20/0x21
      expect_resp(1'b1, WORD_EN ? 32'hABCD1234 : 32'h12341234, WORD_EN ? 2 * (2 + RW) : 2 + RW);
      do_req("w_rd", 1'b0, 2'd2, 19'h00040, 32'h0, t);
      wait_resp("w_rd", t);
      check("w_rd_addr0", 32'(o_addr0), 32'h20);
      check("w_rd_oe_cycles", 32'(o_oe), WORD_EN ? 32'd4 : 32'd2);

      // write directly after a read goes through a turnaround cycle
      expect_resp(1'b0, 32'h0, 3 + WW);
      do_req("ta_wr", 1'b1, 2'd1, 19'h00012, 32'hBEEF0000, t);
      wait_resp("ta_wr", t);
      check("ta_wr_turn_idle", 32'(o_ce_first), 32'd1);
      check("ta_wr_addr", 32'(o_addr0), 32'h9);
      check("ta_wr_dq", 32'(o_dq0), 32'hBEEF);
      check("ta_dq_oe_rises", 32'(rise_cnt > 0), 32'd1);
      check("ta_gap_min2", 32'(min_gap >= 2), 32'd1);

      // read-backs through the SRAM model
      expect_resp(1'b1, 32'hBEEFBEEF, 2 + RW);
      do_req("hw_rd", 1'b0, 2'd1, 19'h00012, 32'h0, t);
      wait_resp("hw_rd", t);

      expect_resp(1'b1, 32'h77007700, 2 + RW);
      do_req("b_rd_hi", 1'b0, 2'd0, 19'h00003, 32'h0, t);
      wait_resp("b_rd_hi", t);
      check("b_rd_hi_byte_n", 32'(o_byte), 32'b01);

      expect_resp(1'b1, 32'hA5C3A5C3, 2 + RW);
      do_req("b_rd_lo", 1'b0, 2'd0, 19'h00010, 32'h0, t);
      wait_resp("b_rd_lo", t);
      check("b_rd_lo_byte_n", 32'(o_byte), 32'b10);

      expect_resp(1'b1, WORD_EN ? 32'h11112222 : 32'h22222222, WORD_EN ? 2 * (2 + RW) : 2 + RW);
      do_req("w_rd2", 1'b0, 2'd2, 19'h00004, 32'h0, t);
      wait_resp("w_rd2", t);

      expect_resp(1'b1, WORD_EN ? 32'h5555AAAA : 32'hAAAAAAAA, WORD_EN ? 2 * (2 + RW) : 2 + RW);
      do_req("top_rd", 1'b0, 2'd2, 19'h7FFFC, 32'h0, t);
      wait_resp("top_rd", t);
      check("top_rd_addr1", 32'(o_addr1), WORD_EN ? 32'h3FFFF : 32'h3FFFE);

      @(negedge clk);
      check("end_idle_ready", 32'(req_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
